// File: rtl/shift_operand_sequencer_pkg.sv
// Shared types and decode helpers for the Operand2 sequencer.
// Holds the state encoding, IR class constants and R15 bypass predicates.
package shift_operand_sequencer_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;

    localparam logic [2:0] CLS_REG = 3'b000;
    localparam logic [2:0] CLS_IMM = 3'b001;
    localparam logic [REG_AW-1:0] R15 = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_RM = 3'd1,
        S_WT_RM = 3'd2,
        S_RD_RS = 3'd3,
        S_WT_RS = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    function automatic logic need_rm(input logic [DATA_W-1:0] ir);
        return ir[27:25] == CLS_REG;
    endfunction

    function automatic logic need_rs(input logic [DATA_W-1:0] ir);
        return (ir[27:25] == CLS_REG) && ir[4];
    endfunction

    function automatic state_e after_rm(input logic [DATA_W-1:0] ir);
        if (need_rs(ir) && ir[11:8] != R15) return S_RD_RS;
        return S_SHIFT;
    endfunction

    function automatic state_e after_idle(input logic [DATA_W-1:0] ir);
        if (need_rm(ir) && ir[3:0] != R15) return S_RD_RM;
        return after_rm(ir);
    endfunction

endpackage

// File: rtl/shift_operand_sequencer_if.sv
// Control-unit and register-file bundle of the Operand2 sequencer.
// master = control unit / register file side, slave = sequencer side.
interface shift_operand_sequencer_if;
    import shift_operand_sequencer_pkg::*;

    logic              Start;
    logic [DATA_W-1:0] IR;
    logic              SR29_IN;
    logic [DATA_W-1:0] PcPlus8;
    logic              Flush;
    logic              RdEn;
    logic [REG_AW-1:0] RdAddr;
    logic [DATA_W-1:0] RdData;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] Operand2;
    logic              ShCarry;

    modport master (
        output Start, IR, SR29_IN, PcPlus8, Flush, RdData,
        input  RdEn, RdAddr, Busy, Done, Operand2, ShCarry
    );

    modport slave (
        input  Start, IR, SR29_IN, PcPlus8, Flush, RdData,
        output RdEn, RdAddr, Busy, Done, Operand2, ShCarry
    );

endinterface

// File: rtl/shift_operand_sequencer_barrel.sv
// ARM Operand2 barrel shifter: rotated immediate, immediate or register shifts.
// Purely combinational; fed from the sequencer's latched operands.
module BarrelShifter
    import shift_operand_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] Rs,
    input  logic [DATA_W-1:0] Rm,
    input  logic [DATA_W-1:0] IR,
    input  logic              SR29_IN,
    output logic              SR29_OUT,
    output logic [DATA_W-1:0] Out
);

    logic [32:0] wide;
    logic [63:0] dbl;
    logic [7:0]  amt;
    logic [4:0]  rot;
    logic        rrx;
    logic        unused_bits;

    assign unused_bits = ^{Rs[31:8], IR[31:28], IR[24:12]};

    always_comb begin
        Out      = Rm;
        SR29_OUT = SR29_IN;
        wide     = '0;
        dbl      = '0;
        amt      = '0;
        rot      = '0;
        rrx      = 1'b0;
        if (IR[27:25] == CLS_IMM) begin
            rot = {IR[11:8], 1'b0};
            dbl = {24'b0, IR[7:0], 24'b0, IR[7:0]} >> rot;
            Out = dbl[31:0];
            if (rot != 5'd0) SR29_OUT = Out[31];
        end else begin
            // Immediate amount 0 encodes LSR/ASR #32 and RRX
            if (IR[4]) amt = Rs[7:0];
            else if (IR[11:7] == 5'd0 && IR[6:5] != 2'b00) amt = 8'd32;
            else amt = {3'b000, IR[11:7]};
            rrx = !IR[4] && IR[11:7] == 5'd0 && IR[6:5] == 2'b11;
            if (rrx) begin
                Out      = {SR29_IN, Rm[31:1]};
                SR29_OUT = Rm[0];
            end else if (amt != 8'd0) begin
                unique case (IR[6:5])
                    2'b00: begin
                        wide     = {1'b0, Rm} << amt;
                        Out      = wide[31:0];
                        SR29_OUT = wide[32];
                    end
                    2'b01: begin
                        wide     = {Rm, 1'b0} >> amt;
                        Out      = wide[32:1];
                        SR29_OUT = wide[0];
                    end
                    2'b10: begin
                        wide     = $signed({Rm, 1'b0}) >>> amt;
                        Out      = wide[32:1];
                        SR29_OUT = wide[0];
                    end
                    2'b11: begin
                        dbl      = {Rm, Rm} >> amt[4:0];
                        Out      = dbl[31:0];
                        SR29_OUT = Out[31];
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_operand_sequencer.sv
// Multicycle Operand2 sequencer: fetches Rm/Rs through one read port,
// runs the barrel shifter and reports Done with the registered result.
module shift_operand_sequencer #(
    parameter int READ_LAT = 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    shift_operand_sequencer_if.slave bus
);
    import shift_operand_sequencer_pkg::*;

    localparam int CW = $clog2(READ_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(READ_LAT - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              c_q, c_d;
    logic [DATA_W-1:0] rm_q, rm_d;
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic              shc_q, shc_d;
    logic [DATA_W-1:0] sh_out;
    logic              sh_c;

    BarrelShifter u_shifter (
        .Rs       (rs_q),
        .Rm       (rm_q),
        .IR       (ir_q),
        .SR29_IN  (c_q),
        .SR29_OUT (sh_c),
        .Out      (sh_out)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ir_q    <= '0;
            c_q     <= 1'b0;
            rm_q    <= '0;
            rs_q    <= '0;
            op2_q   <= '0;
            shc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            c_q     <= c_d;
            rm_q    <= rm_d;
            rs_q    <= rs_d;
            op2_q   <= op2_d;
            shc_q   <= shc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        c_d     = c_q;
        rm_d    = rm_q;
        rs_d    = rs_q;
        op2_d   = op2_q;
        shc_d   = shc_q;
        if (bus.Flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (bus.Start) begin
                    ir_d    = bus.IR;
                    c_d     = bus.SR29_IN;
                    // R15 operands come from PcPlus8 instead of a read
                    rm_d    = (need_rm(bus.IR) && bus.IR[3:0] == R15)
                              ? bus.PcPlus8 : '0;
                    rs_d    = (need_rs(bus.IR) && bus.IR[11:8] == R15)
                              ? bus.PcPlus8 : '0;
                    cnt_d   = '0;
                    state_d = after_idle(bus.IR);
                end
                S_RD_RM: begin
                    cnt_d   = '0;
                    state_d = S_WT_RM;
                end
                S_WT_RM: begin
                    if (cnt_q == LAST) begin
                        rm_d    = bus.RdData;
                        state_d = after_rm(ir_q);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RD_RS: begin
                    cnt_d   = '0;
                    state_d = S_WT_RS;
                end
                S_WT_RS: begin
                    if (cnt_q == LAST) begin
                        rs_d    = bus.RdData;
                        state_d = S_SHIFT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SHIFT: begin
                    op2_d   = sh_out;
                    shc_d   = sh_c;
                    state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.RdEn   = 1'b0;
        bus.RdAddr = '0;
        unique case (state_q)
            S_RD_RM: begin
                bus.RdEn   = ~bus.Flush;
                bus.RdAddr = ir_q[3:0];
            end
            S_RD_RS: begin
                bus.RdEn   = ~bus.Flush;
                bus.RdAddr = ir_q[11:8];
            end
            default: ;
        endcase
    end

    assign bus.Busy     = state_q != S_IDLE;
    assign bus.Done     = state_q == S_DONE;
    assign bus.Operand2 = op2_q;
    assign bus.ShCarry  = shc_q;

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Directed bench for the Operand2 sequencer with a 1-cycle register file.
module tb_shift_operand_sequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   lat;
    logic [31:0] rf [16];
    logic [3:0]  rd_log[$];

    shift_operand_sequencer_if bif();

    shift_operand_sequencer #(.READ_LAT(1)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bif.RdEn) begin
            bif.RdData <= rf[bif.RdAddr];
            rd_log.push_back(bif.RdAddr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] ir, input logic c, input logic [31:0] pc,
                          input bit poke, output int l);
        @(negedge clk);
        rd_log.delete();
        bif.IR = ir;
        bif.SR29_IN = c;
        bif.PcPlus8 = pc;
        bif.Start = 1'b1;
        @(posedge clk); #1;
        bif.Start = 1'b0;
        l = 1;
        while (!bif.Done && l < 20) begin
            if (poke && l == 2) begin
                bif.Start = 1'b1;
                bif.IR = 32'h02000801;
                bif.PcPlus8 = 32'hDEAD;
                bif.SR29_IN = ~c;
            end
            @(posedge clk); #1;
            bif.Start = 1'b0;
            l++;
        end
        chk("done_seen", {31'b0, bif.Done}, 32'd1);
        if (poke) begin
            bif.Start = 1'b1;
            @(posedge clk); #1;
            bif.Start = 1'b0;
            chk("start_in_done", {31'b0, bif.Busy}, 32'd0);
        end else begin
            @(posedge clk); #1;
            chk("done_one_cycle", {31'b0, bif.Done}, 32'd0);
        end
    endtask

    task automatic chk_result(input string tag, input int l, input int exp_lat,
                              input logic [31:0] op2, input logic c, input int nrd);
        chk({tag, "_lat"}, l, exp_lat);
        chk({tag, "_op2"}, bif.Operand2, op2);
        chk({tag, "_c"}, {31'b0, bif.ShCarry}, {31'b0, c});
        chk({tag, "_nrd"}, rd_log.size(), nrd);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bif.Start = 1'b0;
        bif.IR = '0;
        bif.SR29_IN = 1'b0;
        bif.PcPlus8 = '0;
        bif.Flush = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 32'h1111_0000 + i;
        rf[1] = 32'd8;
        rf[2] = 32'd1;
        rf[3] = 32'd1;
        rf[5] = 32'h8000_0001;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, bif.Busy}, 32'd0);
        chk("rst_done", {31'b0, bif.Done}, 32'd0);
        chk("rst_rden", {31'b0, bif.RdEn}, 32'd0);
        chk("rst_rdaddr", {28'b0, bif.RdAddr}, 32'd0);
        chk("rst_op2", bif.Operand2, 32'd0);
        chk("rst_c", {31'b0, bif.ShCarry}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(32'h02000801, 1'b0, 32'h0, 1'b0, lat);
        chk_result("imm", lat, 2, 32'h0001_0000, 1'b0, 0);

        launch(32'h00000103, 1'b0, 32'h0, 1'b0, lat);
        chk_result("lsl2", lat, 4, 32'h4, 1'b0, 1);
        chk("lsl2_addr", {28'b0, rd_log[0]}, 32'd3);

        launch(32'h00000231, 1'b0, 32'h0, 1'b0, lat);
        chk_result("lsr_reg", lat, 6, 32'h4, 1'b0, 2);
        chk("lsr_reg_a0", {28'b0, rd_log[0]}, 32'd1);
        chk("lsr_reg_a1", {28'b0, rd_log[1]}, 32'd2);

        launch(32'h00000231, 1'b1, 32'h0, 1'b1, lat);
        chk_result("busy_start", lat, 6, 32'h4, 1'b0, 2);

        launch(32'h000000A5, 1'b0, 32'h0, 1'b0, lat);
        chk_result("lsr1_carry", lat, 4, 32'h4000_0000, 1'b1, 1);

        launch(32'h00000045, 1'b0, 32'h0, 1'b0, lat);
        chk_result("asr32", lat, 4, 32'hFFFF_FFFF, 1'b1, 1);

        launch(32'h00000F11, 1'b1, 32'h4, 1'b0, lat);
        chk_result("rs_r15", lat, 4, 32'h80, 1'b0, 1);
        chk("rs_r15_addr", {28'b0, rd_log[0]}, 32'd1);

        launch(32'h0000000F, 1'b1, 32'h108, 1'b0, lat);
        chk_result("rm_r15", lat, 2, 32'h108, 1'b1, 0);

        // Flush while waiting for Rs
        @(negedge clk);
        bif.IR = 32'h00000231;
        bif.Start = 1'b1;
        @(posedge clk); #1;
        bif.Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_pre_busy", {31'b0, bif.Busy}, 32'd1);
        bif.Flush = 1'b1;
        @(posedge clk); #1;
        bif.Flush = 1'b0;
        chk("flush_busy", {31'b0, bif.Busy}, 32'd0);
        chk("flush_done", {31'b0, bif.Done}, 32'd0);
        chk("flush_op2", bif.Operand2, 32'h108);
        chk("flush_c", {31'b0, bif.ShCarry}, 32'd1);

        launch(32'h02000801, 1'b0, 32'h0, 1'b0, lat);
        chk_result("post_flush", lat, 2, 32'h0001_0000, 1'b0, 0);

        @(negedge clk);
        bif.Start = 1'b1;
        bif.Flush = 1'b1;
        @(posedge clk); #1;
        bif.Start = 1'b0;
        bif.Flush = 1'b0;
        chk("flush_start_idle", {31'b0, bif.Busy}, 32'd0);

        // Reset pulled while in SHIFT
        @(negedge clk);
        bif.IR = 32'h0000000F;
        bif.PcPlus8 = 32'h2468;
        bif.SR29_IN = 1'b1;
        bif.Start = 1'b1;
        @(posedge clk); #1;
        bif.Start = 1'b0;
        chk("shift_busy", {31'b0, bif.Busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, bif.Busy}, 32'd0);
        chk("arst_op2", bif.Operand2, 32'd0);
        chk("arst_c", {31'b0, bif.ShCarry}, 32'd0);
        chk("arst_done", {31'b0, bif.Done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(32'h00000103, 1'b0, 32'h0, 1'b0, lat);
        chk_result("post_rst", lat, 4, 32'h4, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
